rf_op_sequencer: RTL

//  Initiator side of the 8x8 register-file port set: accepts one register-op command,

---
 rtl/rf_op_sequencer_if.sv | 42 ++++
 rtl/rf_op_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer_if.sv
// Command and register-file port bundle between the instruction decoder,
// the op sequencer and the 8x8 register file.
interface rf_op_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // Decoder -> sequencer command handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;

  // Sequencer <-> register file
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Status
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_c;
  logic              done;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rdata1, rdata2,
    output cmd_ready, raddr1, raddr2, we, waddr, wdata, result, flag_z, flag_c, done
  );

  // Decoder / register-file side
  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rdata1, rdata2,
    input  cmd_ready, raddr1, raddr2, we, waddr, wdata, result, flag_z, flag_c, done
  );
endinterface

// File: rtl/rf_op_sequencer.sv
// Register-op sequencer: accepts one command, reads two operands from the
// register file, computes an ALU result and writes it back. Fixed four-cycle
// IDLE -> READ -> EXEC -> WRITE sequence per command.
module rf_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic                clk,
  input logic                areset,
  rf_op_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_CMP = 3'b111
  } op_t;

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum_ext;
  logic              accept;

  assign accept = bus.cmd_valid && (state == S_IDLE);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of process evaluation order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake/write-strobe decode from the registered state only
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    bus.cmd_ready = 1'b0;
    bus.we        = 1'b0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = S_READ;
      end
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WRITE;
      S_WRITE: begin
        bus.done   = 1'b1;
        bus.we     = (op_q != OP_CMP);
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Latch command fields and read addresses on accept; held until next accept
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      op_q       <= OP_ADD;
      rd_q       <= '0;
      imm_q      <= '0;
      bus.raddr1 <= '0;
      bus.raddr2 <= '0;
    end else if (accept) begin
      op_q       <= op_t'(bus.cmd_op);
      rd_q       <= bus.cmd_rd;
      imm_q      <= bus.cmd_imm;
      bus.raddr1 <= bus.cmd_rs1;
      bus.raddr2 <= bus.cmd_rs2;
    end
  end

  // Capture operands from the combinational register-file read during READ
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_READ) begin
      a_q <= bus.rdata1;
      b_q <= bus.rdata2;
    end
  end

  // ALU: result and carry/borrow for the latched opcode
  always_comb begin
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_MOV:  alu_res = a_q;
      OP_LDI:  alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  // Register result and flags at the end of EXEC; held everywhere else
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bus.result <= '0;
      bus.flag_z <= 1'b0;
      bus.flag_c <= 1'b0;
    end else if (state == S_EXEC) begin
      bus.result <= alu_res;
      bus.flag_z <= (alu_res == '0);
      bus.flag_c <= alu_c;
    end
  end

  // Write port is driven straight from registered fields
  assign bus.waddr = rd_q;
  assign bus.wdata = bus.result;

endmodule
